// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : config_chain_loader
//  Description : Streams host bitstream words LSB-first into the serial
//                configuration chain of a fabric tile, counting exactly
//                CHAIN_LENGTH bits, and holds the logic elements in reset
//                until the whole chain has been loaded.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 68,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_data_in,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  output logic                  o_config_bit,
  output logic                  o_config_shift,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fabric_nreset
);

  localparam int c_REMAIN_W = $clog2(CHAIN_LENGTH + 1);
  localparam int c_WBIT_W   = $clog2(WORD_WIDTH + 1);
  localparam int c_CMP_W    = (c_REMAIN_W > c_WBIT_W) ? c_REMAIN_W : c_WBIT_W;

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_LOAD  = 2'd1;
  localparam logic [1:0] c_S_SHIFT = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  localparam logic [c_REMAIN_W-1:0] c_REMAIN_FULL = c_REMAIN_W'(CHAIN_LENGTH);
  localparam logic [c_REMAIN_W-1:0] c_REMAIN_ONE  = c_REMAIN_W'(1);
  localparam logic [c_WBIT_W-1:0]   c_WBIT_FULL   = c_WBIT_W'(WORD_WIDTH);
  localparam logic [c_WBIT_W-1:0]   c_WBIT_ONE    = c_WBIT_W'(1);
  localparam logic [c_CMP_W-1:0]    c_WORD_CMP    = c_CMP_W'(WORD_WIDTH);

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [WORD_WIDTH-1:0] r_sreg;
  logic [c_REMAIN_W-1:0] r_remain;
  logic [c_WBIT_W-1:0]   r_wbit;

  // Bits to shift from a freshly accepted word: a full word, or only what is
  // left of the chain so the unused upper bits of the last word are dropped.
  logic [c_CMP_W-1:0]    w_remain_cmp;
  logic [c_WBIT_W-1:0]   w_first_wbit;

  assign w_remain_cmp = c_CMP_W'(r_remain);
  assign w_first_wbit = (w_remain_cmp < c_WORD_CMP) ? c_WBIT_W'(r_remain) : c_WBIT_FULL;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; start is only honoured from IDLE or DONE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (i_start) w_state_next = c_S_LOAD;
      end
      c_S_LOAD: begin
        if (i_data_valid) w_state_next = c_S_SHIFT;
      end
      c_S_SHIFT: begin
        if (r_wbit == c_WBIT_ONE) begin
          w_state_next = (r_remain == c_REMAIN_ONE) ? c_S_DONE : c_S_LOAD;
        end
      end
      c_S_DONE: begin
        if (i_start) w_state_next = c_S_LOAD;
      end
      default: w_state_next = c_S_IDLE;
    endcase
  end

  // Datapath: word capture, serialisation and the two bit counters
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sreg   <= '0;
      r_remain <= '0;
      r_wbit   <= '0;
    end else begin
      case (r_state)
        c_S_IDLE, c_S_DONE: begin
          if (i_start) r_remain <= c_REMAIN_FULL;
        end
        c_S_LOAD: begin
          if (i_data_valid) begin
            r_sreg <= i_data_in;
            r_wbit <= w_first_wbit;
          end
        end
        c_S_SHIFT: begin
          r_sreg   <= r_sreg >> 1;
          r_wbit   <= r_wbit - c_WBIT_ONE;
          r_remain <= r_remain - c_REMAIN_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded purely from registered state, never from inputs
  always_comb begin
    o_data_ready    = 1'b0;
    o_config_shift  = 1'b0;
    o_config_bit    = 1'b0;
    o_busy          = 1'b0;
    o_done          = 1'b0;
    o_fabric_nreset = 1'b0;
    case (r_state)
      c_S_LOAD: begin
        o_data_ready = 1'b1;
        o_busy       = 1'b1;
      end
      c_S_SHIFT: begin
        o_config_shift = 1'b1;
        o_config_bit   = r_sreg[0];
        o_busy         = 1'b1;
      end
      c_S_DONE: begin
        o_done          = 1'b1;
        o_fabric_nreset = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_config_chain_loader
//  Description : Self-checking bench for config_chain_loader (68x8 and 16x8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_config_chain_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_start, a_valid, a_ready, a_shift, a_bit, a_busy, a_done, a_nrst;
  logic [7:0] a_data;
  logic       b_start, b_valid, b_ready, b_shift, b_bit, b_busy, b_done, b_nrst;
  logic [7:0] b_data;

  config_chain_loader #(.CHAIN_LENGTH(68), .WORD_WIDTH(8)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(a_start), .i_data_in(a_data),
    .i_data_valid(a_valid), .o_data_ready(a_ready), .o_config_bit(a_bit),
    .o_config_shift(a_shift), .o_busy(a_busy), .o_done(a_done),
    .o_fabric_nreset(a_nrst)
  );

  config_chain_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_data_in(b_data),
    .i_data_valid(b_valid), .o_data_ready(b_ready), .o_config_bit(b_bit),
    .o_config_shift(b_shift), .o_busy(b_busy), .o_done(b_done),
    .o_fabric_nreset(b_nrst)
  );

  typedef struct {
    logic [7:0] base;        // word k = base + k
    int         stall_word;  // index of the word preceded by a stall (-1 none)
    int         stall_len;   // stall cycles in that LOAD
    int         exp_cycles;  // start edge to done, in cycles
    int         exp_shifts;  // config_shift pulses
  } vec_t;

  vec_t       vecs [4];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] words [16];
  logic [7:0] acc [$];   // words accepted by the loader, in order
  logic       cap [$];   // bits seen on the chain, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // {ready, shift, bit, busy, done, nreset}
  function automatic logic [5:0] outs(input int sel);
    if (sel == 0) return {a_ready, a_shift, a_bit, a_busy, a_done, a_nrst};
    return {b_ready, b_shift, b_bit, b_busy, b_done, b_nrst};
  endfunction

  task automatic drive(input int sel, input logic s, input logic v, input logic [7:0] d);
    if (sel == 0) begin a_start = s; a_valid = v; a_data = d; end
    else          begin b_start = s; b_valid = v; b_data = d; end
  endtask

  // One complete configuration; called at posedge+1 with the DUT in IDLE/DONE.
  task automatic run_load(input string name, input int sel, input int len,
                          input int stall_word, input int stall_len,
                          input bit rnd, input int exp_cycles);
    logic [5:0] o;
    int         k = 0, stalled = 0, stalls = 0, viol = 0, bad = 0, n, exp_c, nwords;
    logic       v, s;
    logic [7:0] d;
    bit         finished = 1'b0;
    acc.delete();
    cap.delete();
    drive(sel, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 8'h00);
    n = 1;
    o = outs(sel);
    check({name, " ready/busy after start"}, {30'd0, o[5], o[2]}, 32'd3);
    check({name, " done/nreset low after start"}, {30'd0, o[1], o[0]}, 32'd0);
    while (n <= 400 && !finished) begin
      o = outs(sel);
      if (o[1]) begin
        finished = 1'b1;
      end else begin
        if (o[4]) cap.push_back(o[3]);
        if (o[4] && o[5]) viol++;
        if (o[4] && !o[2]) viol++;
        if (o[0]) viol++;
        if (rnd) begin
          v = ($urandom_range(0, 2) != 0);
          d = 8'($urandom);
          s = o[2] && ($urandom_range(0, 4) == 0);
        end else begin
          v = !(o[5] && k == stall_word && stalled < stall_len);
          if (!v) stalled++;
          d = words[k & 15];
          s = 1'b0;
        end
        if (o[5] && v) begin acc.push_back(d); k++; end
        if (o[5] && !v) stalls++;
        drive(sel, s, v, d);
        @(posedge clk); #1;
        n++;
      end
    end
    drive(sel, 1'b0, 1'b0, 8'h00);
    check({name, " done reached"}, {31'd0, finished}, 32'd1);
    o = outs(sel);
    check({name, " done outputs {rdy,sh,busy,done,nrst}"},
          {27'd0, o[5], o[4], o[2], o[1], o[0]}, 32'b00011);
    nwords = (len + 7) / 8;
    exp_c  = (exp_cycles >= 0) ? exp_cycles : 1 + nwords + len + stalls;
    check({name, " cycles to done"}, n, exp_c);
    check({name, " shift count"}, cap.size(), len);
    check({name, " words consumed"}, acc.size(), nwords);
    for (int i = 0; i < len; i++) begin
      if (i / 8 >= acc.size() || i >= cap.size()) bad++;
      else if (cap[i] !== acc[i / 8][i % 8]) bad++;
    end
    check({name, " stream bit mismatches"}, bad, 0);
    check({name, " protocol violations"}, viol, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0]  o;
    logic [5:0]  acc_o;
    logic [15:0] got16;
    logic [15:0] exp16;
    int          cnt, n;

    vecs[0] = '{8'h01, -1, 0, 78, 68};
    vecs[1] = '{8'h10,  1, 5, 83, 68};
    vecs[2] = '{8'hF0,  0, 3, 81, 68};
    vecs[3] = '{8'hFE,  8, 2, 80, 68};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs A", {26'd0, outs(0)}, 32'd0);
    check("reset outputs B", {26'd0, outs(1)}, 32'd0);
    rst = 1'b0;

    // valid with no start: nothing consumed, nothing shifted
    acc_o = '0;
    drive(0, 1'b0, 1'b1, 8'hAA);
    repeat (3) begin @(posedge clk); #1; acc_o |= outs(0); end
    drive(0, 1'b0, 1'b0, 8'h00);
    check("idle ignores valid", {26'd0, acc_o}, 32'd0);

    // table of full loads on the 68-bit chain, back to back (reconfiguration)
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 16; k++) words[k] = vecs[t].base + 8'(k);
      run_load($sformatf("vec%0d", t), 0, vecs[t].exp_shifts, vecs[t].stall_word,
               vecs[t].stall_len, 1'b0, vecs[t].exp_cycles);
    end

    // DONE holds, and valid is ignored there
    acc_o = '0;
    drive(0, 1'b0, 1'b1, 8'h5A);
    repeat (3) begin @(posedge clk); #1; acc_o |= outs(0); end
    drive(0, 1'b0, 1'b0, 8'h00);
    o = outs(0);
    check("done holds, valid ignored", {26'd0, acc_o}, 32'b000011);
    check("done level after hold", {26'd0, o}, 32'b000011);

    // exact multiple on the 16-bit chain
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    run_load("exact16", 1, 16, -1, 0, 1'b0, 19);
    got16 = '0;
    for (int i = 0; i < 16; i++) if (i < cap.size()) got16[i] = cap[i];
    exp16 = 16'h3CA5;
    check("exact16 literal stream", {16'd0, got16}, {16'd0, exp16});

    // asynchronous reset in the middle of a shift burst
    drive(0, 1'b1, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 8'h55);
    cnt = 0;
    n   = 0;
    o   = outs(0);
    if (o[4]) cnt++;
    while (cnt < 31 && n < 200) begin
      @(posedge clk); #1;
      n++;
      o = outs(0);
      if (o[4]) cnt++;
    end
    check("reached bit 30", cnt, 31);
    #2;
    rst = 1'b1;
    #1;
    check("async reset mid-shift outputs", {26'd0, outs(0)}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_o = '0;
    repeat (2) begin @(posedge clk); #1; acc_o |= outs(0); end
    drive(0, 1'b0, 1'b0, 8'h00);
    check("idle after abort", {26'd0, acc_o}, 32'd0);
    for (int k = 0; k < 16; k++) words[k] = 8'hC3 ^ 8'(k * 7);
    run_load("reload", 0, 68, -1, 0, 1'b0, 78);

    // randomized loads with random valid gaps and stray start pulses
    for (int r = 0; r < 6; r++) begin
      run_load($sformatf("rand%0d", r), r % 2, (r % 2 == 0) ? 68 : 16, -1, 0, 1'b1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/config_chain_loader.md
# config_chain_loader

Sequences the configuration of a fabric tile by streaming bitstream words from a host into the serial configuration chain that feeds every logic element's LUT and comb/seq select bits. The block accepts words over a valid/ready handshake, serializes them LSB-first onto the chain, counts exactly `CHAIN_LENGTH` bits, and holds the fabric in reset until the chain is fully loaded. It sits between the tile's configuration port and the daisy-chained config registers of the logic elements.

## Interface
- `CHAIN_LENGTH`, default 68: total configuration bits in the chain; 4 logic elements × 17 bits. Must be ≥ 1.
- `WORD_WIDTH`, default 8: width of the host bitstream word. Must be ≥ 1.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: request a full (re)configuration; sampled only in IDLE or DONE.
- `data_in` input WORD_WIDTH: bitstream word; bit 0 is shifted first.
- `data_valid` input 1: `data_in` holds a valid word.
- `data_ready` output 1: loader accepts a word this cycle.
- `config_bit` output 1: serial data into the chain head.
- `config_shift` output 1: chain shift enable; the chain shifts `config_bit` in on each clock where this is 1.
- `busy` output 1: configuration in progress (LOAD or SHIFT).
- `done` output 1: chain fully loaded.
- `fabric_nreset` output 1: active-low reset to the logic elements; low until configuration completes.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. All outputs are registered or decoded from state and registers only; there are no combinational paths from inputs to outputs.
- Registers:
  - state;
  - shift register `sreg[WORD_WIDTH-1:0]`;
  - remaining-bit counter `remain`, width clog2(CHAIN_LENGTH+1);
  - word-bit counter `wbit`, width clog2(WORD_WIDTH+1).
- IDLE: `start`=1 → LOAD, `remain`←CHAIN_LENGTH. Otherwise stay.
- LOAD: `data_ready`=1.
  - `data_valid`=1 → `sreg`←`data_in`, `wbit`←min(WORD_WIDTH, `remain`), go to SHIFT.
  - Otherwise stay. There is no timeout.
- SHIFT: `config_shift`=1, `config_bit`=`sreg[0]`. Each cycle: `sreg`←`sreg`>>1, `wbit`−1, `remain`−1.
  - When the cycle has `wbit`=1: `remain` becomes 0 → DONE; otherwise → LOAD.
- DONE: `done`=1, `fabric_nreset`=1. `start`=1 → LOAD, `remain`←CHAIN_LENGTH, and `done` and `fabric_nreset` drop the following cycle (reconfiguration).
- Partial last word: only `remain` bits are shifted; the upper unused bits of that word are discarded and never reach the chain.
- `start` in LOAD or SHIFT is ignored. `data_valid` outside LOAD is ignored, and no word is consumed.
- `busy` = (state==LOAD) or (state==SHIFT).
- `fabric_nreset` = (state==DONE), registered. Logic elements therefore never run with a partially shifted config.
- Reset (any time, including mid-SHIFT):
  - state→IDLE;
  - `data_ready`, `config_shift`, `config_bit`, `busy`, `done`, `fabric_nreset` all 0;
  - `sreg`, `remain`, `wbit` all 0.
  - Chain contents are undefined after an aborted load; a new `start` reloads all bits.

## Timing
- `start` high at edge N in IDLE → `data_ready`=1 and `busy`=1 during cycle N+1.
- Handshake at edge M (`data_ready`&`data_valid`) → `config_shift`=1 for cycles M+1 … M+k, where k=min(WORD_WIDTH, `remain`). Then either:
  - `data_ready`=1 at M+k+1; or
  - `done`=`fabric_nreset`=1 at M+k+1.
- Throughput: one word per WORD_WIDTH+1 cycles when `data_valid` is held high.
- With `data_valid` held high, total cycles from the `start` edge to `done`: 1 + ceil(CHAIN_LENGTH/WORD_WIDTH) + CHAIN_LENGTH.
- `config_shift` is never high in two states; it is never high while `data_ready`=1.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle → all outputs 0 immediately, before the next clock edge.
- Full load, defaults (68, 8), `data_valid` always 1, words 0x01..0x09 → exactly 68 `config_shift` pulses. Word 9 shifts only 4 bits (0x9 LSBs 1,0,0,1). `done`=1 at cycle 1+9+68=78 after `start`. Serial stream equals the concatenation of words LSB-first.
- Backpressure: `data_valid` low for 5 cycles in the second LOAD → `data_ready` stays 1, no shifts occur, the loader resumes on valid, and the total bit count is still 68.
- Exact multiple: CHAIN_LENGTH=16, WORD_WIDTH=8, words 0xA5, 0x3C → 16 shifts, stream 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0, `done` at cycle 19.
- Reset mid-SHIFT on bit 30, then `start` → full 68-bit reload. `fabric_nreset` stays 0 until the new `done`.
- Reconfigure: `start` in DONE → `done` and `fabric_nreset` fall the next cycle. `start` pulsed during SHIFT is ignored, and the shift count is unchanged.
